// File: rtl/dmem_pkg.sv
// Shared encodings and types for the multi-cycle data memory controller.
package dmem_pkg;

  // Access size encodings on req_size; 2'd3 is illegal and faults.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Width of the latency down-counter; covers LATENCY 1..15.
  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the datapath and the data memory controller.
interface dmem_if #(
  parameter int XLEN = 32
) ();

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            busy;

  // Requester side (execute/writeback stages).
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Stateless byte-lane steering: store merge, load extraction/extension and
// alignment check for a little-endian word of four byte lanes (XLEN = 32).
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_lane,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rword,
  output logic [3:0]      o_wmask,
  output logic [XLEN-1:0] o_wword,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_misalign
);

  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_rep;

  // Select lanes by size, extend the load value and merge store data into the old word.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    o_wmask    = '0;
    o_rdata    = '0;
    o_misalign = 1'b0;
    w_rep      = i_wdata;
    w_byte     = i_rword[{i_lane, 3'b000} +: 8];
    w_half     = i_rword[{i_lane[1], 4'b0000} +: 16];
    case (i_size)
      SIZE_B: begin
        o_wmask = 4'b0001 << i_lane;
        w_rep   = {4{i_wdata[7:0]}};
        o_rdata = {{(XLEN-8){~i_unsigned & w_byte[7]}}, w_byte};
      end
      SIZE_H: begin
        o_wmask    = i_lane[1] ? 4'b1100 : 4'b0011;
        w_rep      = {2{i_wdata[15:0]}};
        o_rdata    = {{(XLEN-16){~i_unsigned & w_half[15]}}, w_half};
        o_misalign = i_lane[0];
      end
      SIZE_W: begin
        o_wmask    = 4'b1111;
        o_rdata    = i_rword;
        o_misalign = (i_lane != 2'b00);
      end
      default: ;
    endcase
    o_wword = i_rword;
    for (int k = 0; k < 4; k++) begin
      if (o_wmask[k]) o_wword[8*k +: 8] = w_rep[8*k +: 8];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data memory controller: one request at a time, fixed LATENCY,
// byte/half/word accesses with extension, alignment and range faults.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 128,
  parameter int LATENCY    = 2,
  parameter int INIT_INDEX = 1
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int              IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [XLEN-3:0] DEPTH_WORDS = (XLEN-2)'(DEPTH);
  localparam cnt_t            CNT_LOAD    = cnt_t'(LATENCY - 1);

  typedef logic [XLEN-1:0] mem_t [DEPTH];

  // Power-up image of the array: word i holds i, or all zeros.
  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = (INIT_INDEX != 0) ? XLEN'(i) : '0;
    return m;
  endfunction

  mem_t            r_mem = init_mem();
  state_t          r_state;
  cnt_t            r_cnt;
  logic            r_we;
  logic [1:0]      r_size;
  logic            r_unsigned;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_resp_valid;
  logic [XLEN-1:0] r_resp_rdata;
  logic            r_resp_err;

  logic [IDX_W-1:0] w_idx;
  logic [XLEN-1:0]  w_rword;
  logic [XLEN-1:0]  w_wword;
  logic [XLEN-1:0]  w_rdata;
  logic [3:0]       w_wmask;
  logic             w_misalign;
  logic             w_oob;
  logic             w_err;
  logic             w_fire;

  assign w_idx   = r_addr[2 +: IDX_W];
  assign w_rword = r_mem[w_idx];
  assign w_oob   = (r_addr[XLEN-1:2] >= DEPTH_WORDS);
  assign w_err   = w_misalign | w_oob | (r_size == 2'd3);
  assign w_fire  = (r_state == BUSY) && (r_cnt == '0);

  dmem_lane_align #(.XLEN(XLEN)) u_lane_align (
    .i_lane     (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .i_rword    (w_rword),
    .o_wmask    (w_wmask),
    .o_wword    (w_wword),
    .o_rdata    (w_rdata),
    .o_misalign (w_misalign)
  );

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.busy       = (r_state == BUSY);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

  // Control FSM: accept in IDLE, count down in BUSY, register the response on the last edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_we       <= bus.req_we;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_addr     <= bus.req_addr;
            r_wdata    <= bus.req_wdata;
            r_cnt      <= CNT_LOAD;
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
            r_resp_rdata <= (r_we || w_err) ? '0 : w_rdata;
            r_state      <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Commit a good store on its response edge; an edge in reset never writes.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch; only the write enable is qualified by rst.
    if (rst && w_fire && r_we && !w_err) r_mem[w_idx] <= w_wword;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed and random traffic against a
// byte-level reference model, plus a reset-abort scenario at LATENCY = 3.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 128;
  localparam int LAT_A = 2;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  dmem_if #(.XLEN(XLEN)) bus_a ();
  dmem_if #(.XLEN(XLEN)) bus_b ();

  dmem_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(LAT_A), .INIT_INDEX(1)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  dmem_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(LAT_B), .INIT_INDEX(1)) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as an array of words, accesses as byte arithmetic.
  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
    int unsigned word_i, lane, nbytes;
    logic [6:0]  idx;
    logic [63:0] v, span;
    word_i = addr >> 2;
    lane   = {30'd0, addr[1:0]};
    nbytes = (size == SIZE_B) ? 1 : (size == SIZE_H) ? 2 : 4;
    err    = (size == 2'd3) || ((addr % nbytes) != 0) || (word_i >= DEPTH);
    idx    = word_i[6:0];
    rdata  = '0;
    if (err) return;
    if (we) begin
      for (int k = 0; k < int'(nbytes); k++) begin
        int sh;
        sh = 8 * (int'(lane) + k);
        ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << sh)) | (((wdata >> (8 * k)) & 32'hFF) << sh);
      end
    end else begin
      v    = {32'd0, ref_mem[idx]} >> (8 * lane);
      span = 64'd1 << (8 * nbytes);
      v    = v % span;
      if (!uns && nbytes < 4 && v >= (span >> 1)) v = v + (64'h1_0000_0000 - span);
      rdata = v[31:0];
    end
  endfunction

  // Drive one request on bus_a, wait for acceptance, and queue its expected response.
  task automatic issue_a(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit hold, output int acc);
    exp_t e;
    int   waited;
    waited = 0;
    @(negedge clk);
    bus_a.req_valid    = 1'b1;
    bus_a.req_we       = we;
    bus_a.req_size     = size;
    bus_a.req_unsigned = uns;
    bus_a.req_addr     = addr;
    bus_a.req_wdata    = wdata;
    while (!bus_a.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus_a.req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus_a.req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    model(we, size, uns, addr, wdata, e.rdata, e.err);
    e.acc_cyc = acc;
    exp_q.push_back(e);
    if (!hold) bus_a.req_valid = 1'b0;
    @(negedge clk);
    check("ready_low_in_busy", 32'(bus_a.req_ready), 32'd0);
    check("busy_high_in_busy", 32'(bus_a.busy), 32'd1);
  endtask

  // Monitor for bus_a: pop and compare on every response, check pulse width and hold.
  logic        prev_v_a;
  logic [31:0] last_rdata_a;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_a) begin
      prev_v_a     = 1'b0;
      last_rdata_a = '0;
    end else if (bus_a.resp_valid) begin
      check("resp_pulse_one_cycle", 32'(prev_v_a), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", bus_a.resp_rdata, e.rdata);
        check("resp_err", 32'(bus_a.resp_err), 32'(e.err));
        check("resp_latency", 32'(cyc - e.acc_cyc), 32'(LAT_A));
        last_rdata_a = e.rdata;
      end
      prev_v_a = 1'b1;
    end else begin
      check("rdata_hold", bus_a.resp_rdata, last_rdata_a);
      prev_v_a = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc, acc0, acc1, acc2, waited, n_resp_b, acc_b;
    logic        we, uns;
    logic [1:0]  size;
    logic [31:0] addr;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i);
    bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_size = SIZE_W;
    bus_a.req_unsigned = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_size = SIZE_W;
    bus_b.req_unsigned = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready",      32'(bus_a.req_ready),  32'd1);
    check("reset_busy",       32'(bus_a.busy),       32'd0);
    check("reset_resp_valid", 32'(bus_a.resp_valid), 32'd0);
    check("reset_resp_rdata", bus_a.resp_rdata,      32'd0);
    check("reset_resp_err",   32'(bus_a.resp_err),   32'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Directed sequence from the bring-up plan.
    issue_a(1'b0, SIZE_W, 1'b0, 32'h14, 32'h0,  1'b0, acc);
    issue_a(1'b1, SIZE_B, 1'b0, 32'h15, 32'h80, 1'b0, acc);
    issue_a(1'b0, SIZE_W, 1'b0, 32'h14, 32'h0,  1'b0, acc);
    issue_a(1'b0, SIZE_B, 1'b0, 32'h15, 32'h0,  1'b0, acc);
    issue_a(1'b0, SIZE_B, 1'b1, 32'h15, 32'h0,  1'b0, acc);
    issue_a(1'b1, SIZE_H, 1'b0, 32'h1A, 32'hBEEF, 1'b0, acc);
    issue_a(1'b0, SIZE_W, 1'b0, 32'h18, 32'h0,  1'b0, acc);
    issue_a(1'b0, SIZE_H, 1'b0, 32'h1A, 32'h0,  1'b0, acc);
    issue_a(1'b0, SIZE_W, 1'b0, 32'h16, 32'h0,  1'b0, acc);
    issue_a(1'b1, SIZE_W, 1'b0, 32'h200, 32'h12345678, 1'b0, acc);
    issue_a(1'b0, SIZE_W, 1'b0, 32'h00, 32'h0,  1'b0, acc);
    issue_a(1'b0, 2'd3,   1'b0, 32'h04, 32'h0,  1'b0, acc);
    issue_a(1'b1, 2'd3,   1'b0, 32'h04, 32'hFFFFFFFF, 1'b0, acc);

    // Back-to-back word loads with req_valid held high.
    issue_a(1'b0, SIZE_W, 1'b0, 32'h0, 32'h0, 1'b1, acc0);
    issue_a(1'b0, SIZE_W, 1'b0, 32'h4, 32'h0, 1'b1, acc1);
    issue_a(1'b0, SIZE_W, 1'b0, 32'h8, 32'h0, 1'b0, acc2);
    check("b2b_spacing_1", 32'(acc1 - acc0), 32'(LAT_A + 1));
    check("b2b_spacing_2", 32'(acc2 - acc1), 32'(LAT_A + 1));

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = 32'($urandom_range(0, DEPTH * 4 + 31));
      if ($urandom_range(0, 15) == 0) addr = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        if (size == SIZE_H) addr[0] = 1'b0;
        if (size == SIZE_W) addr[1:0] = 2'b00;
      end
      issue_a(we, size, uns, addr, $urandom(), 1'b0, acc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);

    // Reset one cycle after accepting a store: no response, no write.
    @(negedge clk);
    bus_b.req_valid = 1'b1; bus_b.req_we = 1'b1; bus_b.req_size = SIZE_W;
    bus_b.req_unsigned = 1'b0; bus_b.req_addr = 32'h20; bus_b.req_wdata = 32'hDEADBEEF;
    check("b_ready_idle", 32'(bus_b.req_ready), 32'd1);
    @(posedge clk);
    #1 bus_b.req_valid = 1'b0;
    @(negedge clk);
    check("b_busy_after_accept", 32'(bus_b.busy), 32'd1);
    rst_b = 1'b0;
    @(negedge clk);
    check("b_busy_after_reset", 32'(bus_b.busy), 32'd0);
    check("b_valid_after_reset", 32'(bus_b.resp_valid), 32'd0);
    rst_b = 1'b1;
    n_resp_b = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_b.resp_valid) n_resp_b++;
    end
    check("b_no_resp_after_abort", 32'(n_resp_b), 32'd0);

    @(negedge clk);
    bus_b.req_valid = 1'b1; bus_b.req_we = 1'b0; bus_b.req_addr = 32'h20;
    @(posedge clk);
    #1;
    acc_b = cyc;
    bus_b.req_valid = 1'b0;
    waited = 0;
    @(negedge clk);
    while (!bus_b.resp_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("b_load_resp_seen", 32'(bus_b.resp_valid), 32'd1);
    check("b_load_latency", 32'(cyc - acc_b), 32'(LAT_B));
    check("b_load_rdata", bus_b.resp_rdata, 32'h00000008);
    check("b_load_err", 32'(bus_b.resp_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
